// File: rtl/freelist_alloc_sched_if.sv
// Requester-side and freelist-side signal bundle for the tag freelist scheduler.
// master: the scheduler; slave: requesters plus the freelist.
interface freelist_alloc_sched_if #(
    parameter int unsigned NUM_REQ       = 6,
    parameter int unsigned ENTRY_COUNT   = 12,
    parameter int unsigned ALLOC_WIDTH   = 4,
    parameter int unsigned DEALLOC_WIDTH = 4
);
    localparam int unsigned TAG_WIDTH = $clog2(ENTRY_COUNT);
    localparam int unsigned CNT_WIDTH = $clog2(ENTRY_COUNT + 1);

    logic [NUM_REQ-1:0]                          req_vld_i;
    logic [NUM_REQ-1:0]                          req_rdy_o;
    logic [NUM_REQ-1:0]                          rsp_vld_o;
    logic [NUM_REQ-1:0][TAG_WIDTH-1:0]           rsp_tag_o;
    logic [NUM_REQ-1:0]                          rel_vld_i;
    logic [NUM_REQ-1:0][TAG_WIDTH-1:0]           rel_tag_i;
    logic [NUM_REQ-1:0]                          rel_rdy_o;
    logic                                        flush_i;
    logic [ALLOC_WIDTH-1:0]                      fl_alloc_vld_o;
    logic [ALLOC_WIDTH-1:0][TAG_WIDTH-1:0]       fl_alloc_tag_i;
    logic [ALLOC_WIDTH-1:0]                      fl_alloc_rdy_i;
    logic [DEALLOC_WIDTH-1:0]                    fl_dealloc_vld_o;
    logic [DEALLOC_WIDTH-1:0][TAG_WIDTH-1:0]     fl_dealloc_tag_o;
    logic                                        fl_flush_o;
    logic [CNT_WIDTH-1:0]                        inuse_cnt_o;

    modport master (
        input  req_vld_i, rel_vld_i, rel_tag_i, flush_i, fl_alloc_tag_i, fl_alloc_rdy_i,
        output req_rdy_o, rsp_vld_o, rsp_tag_o, rel_rdy_o, fl_alloc_vld_o,
               fl_dealloc_vld_o, fl_dealloc_tag_o, fl_flush_o, inuse_cnt_o
    );

    modport slave (
        output req_vld_i, rel_vld_i, rel_tag_i, flush_i, fl_alloc_tag_i, fl_alloc_rdy_i,
        input  req_rdy_o, rsp_vld_o, rsp_tag_o, rel_rdy_o, fl_alloc_vld_o,
               fl_dealloc_vld_o, fl_dealloc_tag_o, fl_flush_o, inuse_cnt_o
    );
endinterface

// File: rtl/freelist_alloc_sched.sv
// Round-robin scheduler between tag requesters and a multi-port tag freelist:
// packs grants onto alloc ports, buffers and drains releases, sequences flush.
module freelist_alloc_sched #(
    parameter int unsigned NUM_REQ       = 6,
    parameter int unsigned ENTRY_COUNT   = 12,
    parameter int unsigned ALLOC_WIDTH   = 4,
    parameter int unsigned DEALLOC_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    freelist_alloc_sched_if.master bus
);
    localparam int unsigned TAG_WIDTH = $clog2(ENTRY_COUNT);
    localparam int unsigned CNT_WIDTH = $clog2(ENTRY_COUNT + 1);
    localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned APORT_W   = (ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH) : 1;
    localparam int unsigned DPORT_W   = (DEALLOC_WIDTH > 1) ? $clog2(DEALLOC_WIDTH) : 1;
    localparam int unsigned ACNT_W    = $clog2(ALLOC_WIDTH + 1);
    localparam int unsigned DCNT_W    = $clog2(DEALLOC_WIDTH + 1);
    localparam int unsigned SUM_W     = CNT_WIDTH + 1;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t                            state_q, state_d;
    logic [PTR_W-1:0]                  alloc_ptr_q, rel_ptr_q;
    logic [NUM_REQ-1:0]                rel_pend_q;
    logic [NUM_REQ-1:0][TAG_WIDTH-1:0] rel_tag_q;
    logic [NUM_REQ-1:0]                rsp_vld_q;
    logic [NUM_REQ-1:0][TAG_WIDTH-1:0] rsp_tag_q;
    logic                              fl_flush_q;
    logic [CNT_WIDTH-1:0]              inuse_q;

    logic [NUM_REQ-1:0]                gnt;
    logic [NUM_REQ-1:0][APORT_W-1:0]   gnt_port;
    logic [ACNT_W-1:0]                 gnt_cnt;
    logic [PTR_W-1:0]                  gnt_last;
    logic [ALLOC_WIDTH-1:0]            avld;
    logic [NUM_REQ-1:0]                drn;
    logic [DCNT_W-1:0]                 drn_cnt;
    logic [PTR_W-1:0]                  drn_last;
    logic [DEALLOC_WIDTH-1:0]          dvld;
    logic [DEALLOC_WIDTH-1:0][TAG_WIDTH-1:0] dtag;
    logic                              run;
    logic [SUM_W-1:0]                  inuse_next;

    // Grant scan: stops at the first requester whose packed port is not ready.
    always_comb begin : alloc_scan
        logic             stop;
        logic [PTR_W-1:0] r;
        gnt      = '0;
        gnt_port = '0;
        gnt_cnt  = '0;
        gnt_last = alloc_ptr_q;
        avld     = '0;
        stop     = 1'b0;
        r        = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            r = PTR_W'((32'(alloc_ptr_q) + 32'(i)) % NUM_REQ);
            if (bus.req_vld_i[r] && !stop) begin
                if (gnt_cnt < ACNT_W'(ALLOC_WIDTH)) begin
                    if (bus.fl_alloc_rdy_i[APORT_W'(gnt_cnt)]) begin
                        gnt[r]                 = 1'b1;
                        gnt_port[r]            = APORT_W'(gnt_cnt);
                        avld[APORT_W'(gnt_cnt)] = 1'b1;
                        gnt_last               = r;
                        gnt_cnt                = gnt_cnt + ACNT_W'(1);
                    end else begin
                        stop = 1'b1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Release drain scan: the freelist always accepts, so only port count limits it.
    always_comb begin : drain_scan
        logic [PTR_W-1:0] r;
        drn      = '0;
        drn_cnt  = '0;
        drn_last = rel_ptr_q;
        dvld     = '0;
        dtag     = '0;
        r        = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            r = PTR_W'((32'(rel_ptr_q) + 32'(i)) % NUM_REQ);
            if (rel_pend_q[r] && (drn_cnt < DCNT_W'(DEALLOC_WIDTH))) begin
                drn[r]                   = 1'b1;
                dvld[DPORT_W'(drn_cnt)]  = 1'b1;
                dtag[DPORT_W'(drn_cnt)]  = rel_tag_q[r];
                drn_last                 = r;
                drn_cnt                  = drn_cnt + DCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.flush_i)  state_d = FLUSH;
            FLUSH:   if (!bus.flush_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin : fsm_out
        run                  = 1'b0;
        bus.req_rdy_o        = '0;
        bus.fl_alloc_vld_o   = '0;
        bus.rel_rdy_o        = '0;
        bus.fl_dealloc_vld_o = '0;
        bus.fl_dealloc_tag_o = '0;
        if (state_q == RUN && !bus.flush_i) begin
            run                  = 1'b1;
            bus.req_rdy_o        = gnt;
            bus.fl_alloc_vld_o   = avld;
            bus.rel_rdy_o        = ~rel_pend_q;
            bus.fl_dealloc_vld_o = dvld;
            bus.fl_dealloc_tag_o = dtag;
        end
    end

    // Grants and drains of the same cycle net out; clamp keeps the count in range.
    always_comb begin : inuse_calc
        logic [SUM_W-1:0] up;
        up         = SUM_W'(inuse_q) + SUM_W'(gnt_cnt);
        inuse_next = (up < SUM_W'(drn_cnt)) ? '0 : up - SUM_W'(drn_cnt);
        if (inuse_next > SUM_W'(ENTRY_COUNT)) inuse_next = SUM_W'(ENTRY_COUNT);
    end

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            alloc_ptr_q <= '0;
            rel_ptr_q   <= '0;
            rel_pend_q  <= '0;
            rel_tag_q   <= '0;
            rsp_vld_q   <= '0;
            rsp_tag_q   <= '0;
            fl_flush_q  <= 1'b0;
            inuse_q     <= '0;
        end else begin
            fl_flush_q <= (state_d == FLUSH);
            if (state_q == FLUSH) begin
                alloc_ptr_q <= '0;
                rel_ptr_q   <= '0;
                rel_pend_q  <= '0;
                rsp_vld_q   <= '0;
                inuse_q     <= '0;
            end else if (run) begin
                if (gnt != '0) alloc_ptr_q <= PTR_W'((32'(gnt_last) + 32'd1) % NUM_REQ);
                if (drn != '0) rel_ptr_q   <= PTR_W'((32'(drn_last) + 32'd1) % NUM_REQ);
                rsp_vld_q  <= gnt;
                rel_pend_q <= (rel_pend_q & ~drn) | (bus.rel_vld_i & ~rel_pend_q);
                inuse_q    <= CNT_WIDTH'(inuse_next);
                for (int r = 0; r < int'(NUM_REQ); r++) begin
                    if (gnt[r]) rsp_tag_q[r] <= bus.fl_alloc_tag_i[gnt_port[r]];
                    if (bus.rel_vld_i[r] && !rel_pend_q[r]) rel_tag_q[r] <= bus.rel_tag_i[r];
                end
            end else begin
                rsp_vld_q <= '0;
            end
        end
    end

    assign bus.rsp_vld_o   = rsp_vld_q;
    assign bus.rsp_tag_o   = rsp_tag_q;
    assign bus.fl_flush_o  = fl_flush_q;
    assign bus.inuse_cnt_o = inuse_q;
endmodule

// File: tb/tb_freelist_alloc_sched.sv
// Directed bench for freelist_alloc_sched: a vector table for grant packing and
// round-robin, then hand sequences for release drain, counter netting, flush and reset.
module tb_freelist_alloc_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    freelist_alloc_sched_if #(.NUM_REQ(6), .ENTRY_COUNT(12), .ALLOC_WIDTH(4), .DEALLOC_WIDTH(4)) bus ();

    freelist_alloc_sched #(.NUM_REQ(6), .ENTRY_COUNT(12), .ALLOC_WIDTH(4), .DEALLOC_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  req;
        logic [3:0]  rdy;
        logic [15:0] tags;
        logic [5:0]  e_rdy;
        logic [3:0]  e_avld;
        logic [5:0]  e_rvld;
        logic [23:0] e_rtag;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.req_vld_i      = '0;
        bus.rel_vld_i      = '0;
        bus.rel_tag_i      = '0;
        bus.flush_i        = 1'b0;
        bus.fl_alloc_tag_i = '0;
        bus.fl_alloc_rdy_i = '0;
    endtask

    initial begin
        //        req       rdy      tags      e_rdy     e_avld   e_rvld    e_rtag      cnt
        vt[0] = '{6'h3F, 4'hF, 16'h3210, 6'b001111, 4'hF, 6'b000000, 24'h000000, 4'd0};
        vt[1] = '{6'h3F, 4'hF, 16'h7654, 6'b110011, 4'hF, 6'b001111, 24'h003210, 4'd4};
        vt[2] = '{6'h3F, 4'h3, 16'hBA98, 6'b001100, 4'h3, 6'b110011, 24'h543276, 4'd8};
        vt[3] = '{6'h3F, 4'h0, 16'hBA98, 6'b000000, 4'h0, 6'b001100, 24'h549876, 4'd10};
        vt[4] = '{6'h02, 4'hA, 16'hBA98, 6'b000000, 4'h0, 6'b000000, 24'h549876, 4'd10};
        vt[5] = '{6'h21, 4'hF, 16'h00BA, 6'b100001, 4'h3, 6'b000000, 24'h549876, 4'd10};
        vt[6] = '{6'h00, 4'hF, 16'h0000, 6'b000000, 4'h0, 6'b100001, 24'hA4987B, 4'd12};
        vt[7] = '{6'h00, 4'h0, 16'h0000, 6'b000000, 4'h0, 6'b000000, 24'hA4987B, 4'd12};

        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_vld", 32'(bus.rsp_vld_o), 32'h0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag_o), 32'h0);
        chk("rst_flush", 32'(bus.fl_flush_o), 32'h0);
        chk("rst_inuse", 32'(bus.inuse_cnt_o), 32'h0);
        chk("rst_rel_rdy", 32'(bus.rel_rdy_o), 32'h3F);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            idle();
            bus.req_vld_i      = vt[i].req;
            bus.fl_alloc_rdy_i = vt[i].rdy;
            bus.fl_alloc_tag_i = vt[i].tags;
            #1;
            chk($sformatf("v%0d_req_rdy", i), 32'(bus.req_rdy_o), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_alloc_vld", i), 32'(bus.fl_alloc_vld_o), 32'(vt[i].e_avld));
            chk($sformatf("v%0d_rsp_vld", i), 32'(bus.rsp_vld_o), 32'(vt[i].e_rvld));
            chk($sformatf("v%0d_rsp_tag", i), 32'(bus.rsp_tag_o), 32'(vt[i].e_rtag));
            chk($sformatf("v%0d_inuse", i), 32'(bus.inuse_cnt_o), 32'(vt[i].e_cnt));
            @(negedge clk);
        end

        // All six release at once; drains 4 then 2.
        idle();
        bus.rel_vld_i = 6'h3F;
        bus.rel_tag_i = 24'h543210;
        #1;
        chk("relA_rdy", 32'(bus.rel_rdy_o), 32'h3F);
        chk("relA_dvld", 32'(bus.fl_dealloc_vld_o), 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("relB_dvld", 32'(bus.fl_dealloc_vld_o), 32'hF);
        chk("relB_dtag", 32'(bus.fl_dealloc_tag_o), 32'h3210);
        chk("relB_rdy", 32'(bus.rel_rdy_o), 32'h00);
        chk("relB_inuse", 32'(bus.inuse_cnt_o), 32'd12);
        @(negedge clk);
        idle();
        #1;
        chk("relC_dvld", 32'(bus.fl_dealloc_vld_o), 32'h3);
        chk("relC_dtag", 32'(bus.fl_dealloc_tag_o[1:0]), 32'h54);
        chk("relC_rdy", 32'(bus.rel_rdy_o), 32'h0F);
        chk("relC_inuse", 32'(bus.inuse_cnt_o), 32'd8);
        @(negedge clk);
        idle();
        bus.rel_vld_i = 6'b000001;
        bus.rel_tag_i = 24'h000001;
        #1;
        chk("relD_dvld", 32'(bus.fl_dealloc_vld_o), 32'h0);
        chk("relD_rdy", 32'(bus.rel_rdy_o), 32'h3F);
        chk("relD_inuse", 32'(bus.inuse_cnt_o), 32'd6);
        @(negedge clk);

        // Drain r0 while r1,r2 release; then 3 grants and 2 drains net +1 from 5.
        idle();
        bus.rel_vld_i = 6'b000110;
        bus.rel_tag_i = 24'h000760;
        #1;
        chk("netA_dvld", 32'(bus.fl_dealloc_vld_o), 32'h1);
        chk("netA_dtag", 32'(bus.fl_dealloc_tag_o[0]), 32'h1);
        chk("netA_rel_rdy", 32'(bus.rel_rdy_o), 32'h3E);
        @(negedge clk);
        idle();
        bus.req_vld_i      = 6'b001110;
        bus.fl_alloc_rdy_i = 4'hF;
        bus.fl_alloc_tag_i = 16'h0A98;
        #1;
        chk("netB_req_rdy", 32'(bus.req_rdy_o), 32'h0E);
        chk("netB_avld", 32'(bus.fl_alloc_vld_o), 32'h7);
        chk("netB_dvld", 32'(bus.fl_dealloc_vld_o), 32'h3);
        chk("netB_dtag", 32'(bus.fl_dealloc_tag_o[1:0]), 32'h76);
        chk("netB_inuse", 32'(bus.inuse_cnt_o), 32'd5);
        @(negedge clk);

        // Grant r5 and queue two releases just before the flush pulse.
        idle();
        bus.req_vld_i      = 6'b100000;
        bus.fl_alloc_rdy_i = 4'hF;
        bus.fl_alloc_tag_i = 16'h0005;
        bus.rel_vld_i      = 6'b011000;
        bus.rel_tag_i      = 24'h023000;
        #1;
        chk("netC_inuse", 32'(bus.inuse_cnt_o), 32'd6);
        chk("netC_rsp_vld", 32'(bus.rsp_vld_o), 32'h0E);
        chk("netC_rsp_tag", 32'(bus.rsp_tag_o), 32'hA4A98B);
        chk("netC_req_rdy", 32'(bus.req_rdy_o), 32'h20);
        @(negedge clk);

        idle();
        bus.flush_i        = 1'b1;
        bus.req_vld_i      = 6'h3F;
        bus.fl_alloc_rdy_i = 4'hF;
        #1;
        chk("flN_req_rdy", 32'(bus.req_rdy_o), 32'h0);
        chk("flN_avld", 32'(bus.fl_alloc_vld_o), 32'h0);
        chk("flN_dvld", 32'(bus.fl_dealloc_vld_o), 32'h0);
        chk("flN_rel_rdy", 32'(bus.rel_rdy_o), 32'h0);
        chk("flN_rsp_vld", 32'(bus.rsp_vld_o), 32'h20);
        chk("flN_rsp_tag", 32'(bus.rsp_tag_o), 32'h54A98B);
        chk("flN_flush", 32'(bus.fl_flush_o), 32'h0);
        chk("flN_inuse", 32'(bus.inuse_cnt_o), 32'd7);
        @(negedge clk);
        idle();
        bus.req_vld_i      = 6'h3F;
        bus.fl_alloc_rdy_i = 4'hF;
        #1;
        chk("flN1_flush", 32'(bus.fl_flush_o), 32'h1);
        chk("flN1_req_rdy", 32'(bus.req_rdy_o), 32'h0);
        chk("flN1_dvld", 32'(bus.fl_dealloc_vld_o), 32'h0);
        chk("flN1_rel_rdy", 32'(bus.rel_rdy_o), 32'h0);
        chk("flN1_rsp_vld", 32'(bus.rsp_vld_o), 32'h0);
        @(negedge clk);
        idle();
        bus.req_vld_i      = 6'h3F;
        bus.fl_alloc_rdy_i = 4'b0011;
        #1;
        chk("flN2_flush", 32'(bus.fl_flush_o), 32'h0);
        chk("flN2_inuse", 32'(bus.inuse_cnt_o), 32'd0);
        chk("flN2_rel_rdy", 32'(bus.rel_rdy_o), 32'h3F);
        chk("flN2_dvld", 32'(bus.fl_dealloc_vld_o), 32'h0);
        chk("flN2_req_rdy", 32'(bus.req_rdy_o), 32'h03);
        chk("flN2_avld", 32'(bus.fl_alloc_vld_o), 32'h3);
        @(negedge clk);
        idle();
        bus.req_vld_i      = 6'h3F;
        bus.fl_alloc_rdy_i = 4'hF;
        #1;
        chk("flN3_req_rdy", 32'(bus.req_rdy_o), 32'h3C);
        chk("flN3_inuse", 32'(bus.inuse_cnt_o), 32'd2);
        @(negedge clk);

        // Two-cycle flush pulse.
        idle();
        bus.flush_i = 1'b1;
        @(negedge clk);
        idle();
        bus.flush_i = 1'b1;
        #1;
        chk("fl2_a", 32'(bus.fl_flush_o), 32'h1);
        @(negedge clk);
        idle();
        #1;
        chk("fl2_b", 32'(bus.fl_flush_o), 32'h1);
        @(negedge clk);
        idle();
        #1;
        chk("fl2_c", 32'(bus.fl_flush_o), 32'h0);
        chk("fl2_inuse", 32'(bus.inuse_cnt_o), 32'd0);
        @(negedge clk);

        // Reset taken while in the flush state.
        idle();
        bus.flush_i = 1'b1;
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        chk("rstfl_a", 32'(bus.fl_flush_o), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        idle();
        bus.req_vld_i      = 6'h3F;
        bus.fl_alloc_rdy_i = 4'hF;
        #1;
        chk("rstfl_flush", 32'(bus.fl_flush_o), 32'h0);
        chk("rstfl_rel_rdy", 32'(bus.rel_rdy_o), 32'h3F);
        chk("rstfl_rsp_vld", 32'(bus.rsp_vld_o), 32'h0);
        chk("rstfl_req_rdy", 32'(bus.req_rdy_o), 32'h0F);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
